// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port framebuffer RAM between the VGA scan-out prefetcher
// (feeding a pixel FIFO in raster order) and a valid/ready pixel writer.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4
) (
  input  logic              i_clk100MHz,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_pix_rd,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  output logic              o_underflow,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int FRAME_PIX = H_ACT * V_ACT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_PIX);
  localparam logic [LVL_W:0]    OCC_LOW   = (LVL_W + 1)'(LOW_WM);
  localparam logic [LVL_W:0]    OCC_FULL  = (LVL_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                inflight_q, inflight_d;
  logic                underflow_q, underflow_d;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic [LVL_W:0]      occ;
  logic                fetching;
  logic                rd_urgent;
  logic                rd_grant;
  logic                wr_grant;
  logic                wr_in_range;
  logic                mem_wr;
  logic                empty;
  logic                push;
  logic                pop;

  // Grant decode; reads are withheld in the frame_start cycle and everything is
  // masked while reset is asserted so the RAM strobes drop asynchronously.
  always_comb begin
    occ         = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q};
    fetching    = (state_q == ST_FETCH) && !i_frame_start && !i_rst;
    rd_urgent   = fetching && (occ < OCC_LOW);
    wr_grant    = !i_rst && i_wr_valid && !rd_urgent;
    rd_grant    = rd_urgent || (fetching && !i_wr_valid && (occ < OCC_FULL));
    wr_in_range = ({1'b0, i_wr_addr} < FRAME_END);
    mem_wr      = wr_grant && wr_in_range;
    empty       = (level_q == '0);
    push        = inflight_q && !i_frame_start;
    pop         = i_pix_rd && !empty && !i_frame_start;
  end

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    inflight_d  = rd_grant;
    underflow_d = underflow_q;
    if (i_frame_start) begin
      state_d     = ST_FETCH;
      scan_addr_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      if (i_pix_rd && empty) begin
        underflow_d = 1'b1;
      end
      if (rd_grant) begin
        scan_addr_d = scan_addr_q + ADDR_W'(1);
        if (scan_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk100MHz or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      scan_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge i_clk100MHz) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= i_mem_rdata;
    end
  end

  always_comb begin
    o_mem_en    = rd_grant || mem_wr;
    o_mem_we    = mem_wr;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (rd_grant) begin
      o_mem_addr = scan_addr_q;
    end else if (mem_wr) begin
      o_mem_addr  = i_wr_addr;
      o_mem_wdata = i_wr_data;
    end
    o_wr_ready  = wr_grant;
    o_pix_valid = !empty;
    o_pix_data  = empty ? '0 : fifo_mem[rd_ptr_q];
    o_underflow = underflow_q;
  end

endmodule
